// File: rtl/debounce_bank_pkg.sv
// Shared constants and elaboration helpers for the debounce bank.
package debounce_bank_pkg;

  localparam int DEB_EDGE_FALL = 0;
  localparam int DEB_EDGE_RISE = 1;

  // Board clock is 50 MHz: 1 ms filter window, ~1.31 ms stretched pulse.
  localparam int DEB_BOARD_CLK_HZ    = 50_000_000;
  localparam int DEB_STABLE_DEFAULT  = DEB_BOARD_CLK_HZ / 1000;
  localparam int DEB_STRETCH_DEFAULT = 65536;

  function automatic int deb_clog2(input longint value);
    int     bits;
    longint span;
    bits = 0;
    span = 1;
    while (span < value) begin
      span = span << 1;
      bits = bits + 1;
    end
    return bits;
  endfunction

  function automatic longint deb_max(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Pin-side bundle of the debounce bank: raw inputs in, filtered views out.
interface debounce_bank_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] i_raw;
  logic [N_CH-1:0] o_level;
  logic [N_CH-1:0] o_rise;
  logic [N_CH-1:0] o_fall;
  logic [N_CH-1:0] o_stretch;

  modport master (
    output i_raw,
    input  o_level,
    input  o_rise,
    input  o_fall,
    input  o_stretch
  );

  modport slave (
    input  i_raw,
    output o_level,
    output o_rise,
    output o_fall,
    output o_stretch
  );
endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser chain, stability filter with edge
// strobes, and a retriggerable pulse stretcher on the selected edge.
module debounce_ch
  import debounce_bank_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = DEB_STABLE_DEFAULT,
  parameter int STRETCH_CYCLES = DEB_STRETCH_DEFAULT,
  parameter int STRETCH_EDGE   = DEB_EDGE_FALL,
  parameter bit RESET_LEVEL    = 1'b1,
  parameter int CNT_W          = 17
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_stretch
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], i_raw};
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Any return to the accepted level before the terminal count discards the bounce.
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == STABLE_LAST) begin
      level_d = s;
      cnt_d   = '0;
      rise_d  = s;
      fall_d  = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

  generate
    if (STRETCH_CYCLES > 0) begin : g_stretch
      localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);

      logic             stretch_q, stretch_d;
      logic [CNT_W-1:0] scnt_q, scnt_d;
      logic             trig;

      // Trigger from the next-state strobe so the pulse starts with the strobe.
      assign trig = (STRETCH_EDGE == DEB_EDGE_RISE) ? rise_d : fall_d;

      always_comb begin
        stretch_d = stretch_q;
        scnt_d    = scnt_q;
        if (trig) begin
          stretch_d = 1'b1;
          scnt_d    = STRETCH_LAST;
        end else if (stretch_q) begin
          if (scnt_q == '0) begin
            stretch_d = 1'b0;
          end else begin
            scnt_d = scnt_q - 1'b1;
          end
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          stretch_q <= 1'b0;
          scnt_q    <= '0;
        end else begin
          stretch_q <= stretch_d;
          scnt_q    <= scnt_d;
        end
      end

      assign o_stretch = stretch_q;
    end else begin : g_no_stretch
      assign o_stretch = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounce channels between board pins and control logic.
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = DEB_STABLE_DEFAULT,
  parameter int STRETCH_CYCLES = DEB_STRETCH_DEFAULT,
  parameter int STRETCH_EDGE   = DEB_EDGE_FALL,
  parameter bit RESET_LEVEL    = 1'b1,
  parameter int CNT_W          = deb_clog2(deb_max(STABLE_CYCLES, STRETCH_CYCLES) + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  debounce_bank_if.slave  bus
);

  localparam longint CNT_NEED = deb_max(longint'(STABLE_CYCLES), longint'(STRETCH_CYCLES));

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_bank: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("debounce_bank: STABLE_CYCLES must be >= 1");
    end
    if ((longint'(1) << CNT_W) <= CNT_NEED) begin : g_bad_width
      $error("debounce_bank: CNT_W too narrow for STABLE_CYCLES/STRETCH_CYCLES");
    end
    if ((STRETCH_EDGE != DEB_EDGE_FALL) && (STRETCH_EDGE != DEB_EDGE_RISE)) begin : g_bad_edge
      $error("debounce_bank: STRETCH_EDGE must be 0 (fall) or 1 (rise)");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      debounce_ch #(
        .SYNC_STAGES    (SYNC_STAGES),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .STRETCH_CYCLES (STRETCH_CYCLES),
        .STRETCH_EDGE   (STRETCH_EDGE),
        .RESET_LEVEL    (RESET_LEVEL),
        .CNT_W          (CNT_W)
      ) u_ch (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_raw     (bus.i_raw[gi]),
        .o_level   (bus.o_level[gi]),
        .o_rise    (bus.o_rise[gi]),
        .o_fall    (bus.o_fall[gi]),
        .o_stretch (bus.o_stretch[gi])
      );
    end
  endgenerate

endmodule
